// File: rtl/adder_carry_chain_pkg.sv
// Shared definitions for the propagate/generate carry chain.
package adder_carry_chain_pkg;

  localparam int DEF_WIDTH   = 1;
  localparam bit DEF_REG_OUT = 1'b0;

  // Carry select in mux form: propagate passes the incoming carry,
  // otherwise the generate bit alone decides the carry.
  function automatic logic carry_mux(input logic p, input logic g, input logic ci);
    return p ? ci : g;
  endfunction

endpackage

// File: rtl/adder_carry_chain_if.sv
// Data bundle for the carry chain: p/g/cin in, sumout/cout out.
interface adder_carry_chain_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic             cin;
  logic [WIDTH-1:0] sumout;
  logic             cout;

  modport master (output p, g, cin, input  sumout, cout);
  modport slave  (input  p, g, cin, output sumout, cout);
endinterface

// File: rtl/adder_carry_chain_cell.sv
// Single carry cell: sum bit plus carry into the next cell.
module adder_carry_cell
  import adder_carry_chain_pkg::*;
(
  input  logic p_i,
  input  logic g_i,
  input  logic ci_i,
  output logic sumout_o,
  output logic co_o
);

  // Plain XOR / mux so X on any input propagates naturally.
  assign sumout_o = p_i ^ ci_i;
  assign co_o     = carry_mux(p_i, g_i, ci_i);

endmodule

// File: rtl/adder_carry_chain.sv
// Ripple carry chain of WIDTH cells with an optional output register.
module adder_carry_chain
  import adder_carry_chain_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter bit REG_OUT = DEF_REG_OUT
) (
  input  logic                clk,
  input  logic                rst,
  adder_carry_chain_if.slave  bus
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  assign c[0]   = bus.cin;
  assign cout_d = c[WIDTH];

  // Carry ripples cell to cell; no pipelining between cells.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    adder_carry_cell u_cell (
      .p_i      (bus.p[i]),
      .g_i      (bus.g[i]),
      .ci_i     (c[i]),
      .sumout_o (sum_d[i]),
      .co_o     (c[i+1])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Output capture; reset clears immediately and discards in-flight data.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q  <= '0;
        cout_q <= 1'b0;
      end else begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end

    assign bus.sumout = sum_q;
    assign bus.cout   = cout_q;
  end else begin : g_comb
    // Clock and reset are intentionally unused in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};

    assign bus.sumout = sum_d;
    assign bus.cout   = cout_d;
  end

endmodule

// File: tb/tb_adder_carry_chain.sv
// Directed bench for adder_carry_chain: 1-bit primitive, 8-bit comb, 8-bit registered.
module tb_adder_carry_chain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  adder_carry_chain_if #(.WIDTH(1)) if1  ();
  adder_carry_chain_if #(.WIDTH(8)) if8c ();
  adder_carry_chain_if #(.WIDTH(8)) if8r ();

  adder_carry_chain #(.WIDTH(1), .REG_OUT(1'b0)) u_w1 (.clk(clk), .rst(rst), .bus(if1));
  adder_carry_chain #(.WIDTH(8), .REG_OUT(1'b0)) u_w8c (.clk(clk), .rst(rst), .bus(if8c));
  adder_carry_chain #(.WIDTH(8), .REG_OUT(1'b1)) u_w8r (.clk(clk), .rst(rst), .bus(if8r));

  task automatic test_reset();
    if8r.p = 8'h99; if8r.g = 8'h42; if8r.cin = 1'b0;
    if1.p = 1'b0; if1.g = 1'b0; if1.cin = 1'b0;
    if8c.p = 8'h00; if8c.g = 8'h00; if8c.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (if8r.sumout !== 8'h00 || if8r.cout !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: got sum=%h cout=%b want sum=00 cout=0", if8r.sumout, if8r.cout);
    end
  endtask

  task automatic test_exhaustive_w1();
    logic [7:0] exp_cout;
    logic [7:0] exp_sum;
    logic [2:0] v;
    exp_cout = 8'hAC;  // index {p,g,cin}
    exp_sum  = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      if1.p = v[2]; if1.g = v[1]; if1.cin = v[0];
      #1;
      tests++;
      if (if1.cout !== exp_cout[i] || if1.sumout !== exp_sum[i]) begin
        fails++;
        $display("FAIL w1_exh[%0d]: got sum=%b cout=%b want sum=%b cout=%b",
                 i, if1.sumout, if1.cout, exp_sum[i], exp_cout[i]);
      end
    end
  endtask

  task automatic test_random_w1();
    int bad = 0;
    logic ep, eg, ec;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      ep = 1'($urandom); eg = 1'($urandom); ec = 1'($urandom);
      if1.p = ep; if1.g = eg; if1.cin = ec;
      #1;
      if (if1.cout !== (ep ? ec : eg) || if1.sumout !== (ep ^ ec)) begin
        bad++;
        $display("FAIL w1_rand[%0d]: p=%b g=%b cin=%b got sum=%b cout=%b", i, ep, eg, ec,
                 if1.sumout, if1.cout);
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL w1_rand_total: got %0d mismatches want 0", bad);
    end
  endtask

  task automatic test_full_prop();
    if8c.p = 8'hFF; if8c.g = 8'h00; if8c.cin = 1'b1;
    #1;
    tests++;
    if (if8c.sumout !== 8'h00 || if8c.cout !== 1'b1) begin
      fails++;
      $display("FAIL prop_cin1: got sum=%h cout=%b want sum=00 cout=1", if8c.sumout, if8c.cout);
    end
    if8c.cin = 1'b0;
    #1;
    tests++;
    if (if8c.sumout !== 8'hFF || if8c.cout !== 1'b0) begin
      fails++;
      $display("FAIL prop_cin0: got sum=%h cout=%b want sum=ff cout=0", if8c.sumout, if8c.cout);
    end
  endtask

  task automatic test_adder();
    if8c.p = 8'h99; if8c.g = 8'h42; if8c.cin = 1'b0;
    #1;
    tests++;
    if (if8c.sumout !== 8'h1D || if8c.cout !== 1'b1) begin
      fails++;
      $display("FAIL adder_5a_c3: got sum=%h cout=%b want sum=1d cout=1", if8c.sumout, if8c.cout);
    end
    // 0x0F + 0x01 + cin=1 = 0x11: p=0E g=01
    if8c.p = 8'h0E; if8c.g = 8'h01; if8c.cin = 1'b1;
    #1;
    tests++;
    if (if8c.sumout !== 8'h11 || if8c.cout !== 1'b0) begin
      fails++;
      $display("FAIL adder_0f_01_c1: got sum=%h cout=%b want sum=11 cout=0", if8c.sumout, if8c.cout);
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    if8r.p = 8'h00; if8r.g = 8'h00; if8r.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if8r.p = 8'h99; if8r.g = 8'h42; if8r.cin = 1'b0;
    #1;
    tests++;
    if (if8r.sumout !== 8'h00 || if8r.cout !== 1'b0) begin
      fails++;
      $display("FAIL reg_before_edge: got sum=%h cout=%b want sum=00 cout=0", if8r.sumout, if8r.cout);
    end
    @(posedge clk); #1;
    tests++;
    if (if8r.sumout !== 8'h1D || if8r.cout !== 1'b1) begin
      fails++;
      $display("FAIL reg_after_edge: got sum=%h cout=%b want sum=1d cout=1", if8r.sumout, if8r.cout);
    end
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    tests++;
    if (if8r.sumout !== 8'h00 || if8r.cout !== 1'b0) begin
      fails++;
      $display("FAIL reg_async_rst: got sum=%h cout=%b want sum=00 cout=0", if8r.sumout, if8r.cout);
    end
    // Combinational build ignores reset.
    tests++;
    if (if8c.sumout !== 8'h11 || if8c.cout !== 1'b0) begin
      fails++;
      $display("FAIL comb_ignores_rst: got sum=%h cout=%b want sum=11 cout=0", if8c.sumout, if8c.cout);
    end
    @(posedge clk); #1;
    tests++;
    if (if8r.sumout !== 8'h00 || if8r.cout !== 1'b0) begin
      fails++;
      $display("FAIL reg_rst_hold: got sum=%h cout=%b want sum=00 cout=0", if8r.sumout, if8r.cout);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (if8r.sumout !== 8'h00 || if8r.cout !== 1'b0) begin
      fails++;
      $display("FAIL reg_rst_release: got sum=%h cout=%b want sum=00 cout=0", if8r.sumout, if8r.cout);
    end
    @(posedge clk); #1;
    tests++;
    if (if8r.sumout !== 8'h1D || if8r.cout !== 1'b1) begin
      fails++;
      $display("FAIL reg_recover: got sum=%h cout=%b want sum=1d cout=1", if8r.sumout, if8r.cout);
    end
  endtask

  task automatic test_g_insensitive();
    int bad = 0;
    if8c.p = 8'hFF; if8c.cin = 1'b1;
    if1.p = 1'b1; if1.cin = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if8c.g = 8'($urandom);
      if1.g  = 1'($urandom);
      #1;
      if (if8c.sumout !== 8'h00 || if8c.cout !== 1'b1 || if1.sumout !== 1'b1 || if1.cout !== 1'b0) begin
        bad++;
        $display("FAIL g_insens[%0d]: g=%h got sum=%h cout=%b w1 sum=%b cout=%b", i, if8c.g,
                 if8c.sumout, if8c.cout, if1.sumout, if1.cout);
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL g_insens_total: got %0d mismatches want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_exhaustive_w1();
    test_random_w1();
    test_full_prop();
    test_adder();
    test_registered();
    test_g_insensitive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
